// File: rtl/tone_pkg.sv
// Shared types and helpers for the two-channel tone synthesizer.
package tone_pkg;

    localparam int unsigned AMP_W       = 15;
    localparam int unsigned SMP_W       = 16;
    localparam int unsigned SILENCE_MAX = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } ch_state_t;

    // Target envelope amplitude for a volume level; 6 and 7 saturate at level 5.
    function automatic logic [AMP_W-1:0] vol_to_amp(input logic [2:0] vol);
        logic [AMP_W-1:0] amp;
        case (vol)
            3'd0:    amp = 15'h0000;
            3'd1:    amp = 15'h0800;
            3'd2:    amp = 15'h1000;
            3'd3:    amp = 15'h2000;
            3'd4:    amp = 15'h3000;
            default: amp = 15'h4000;
        endcase
        return amp;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One synth channel: divider latch, half-period counter, linear envelope, IDLE/PLAY/RELEASE control.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned DIV_W    = 22,
    parameter logic [15:0] AMP_STEP = 16'h0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [DIV_W-1:0]   note_div,
    input  logic [AMP_W-1:0]   target_amp,
    output logic [SMP_W-1:0]   sample,
    output logic               active
);

    ch_state_t          state;
    logic [DIV_W-1:0]   div_l;
    logic [DIV_W-1:0]   cnt;
    logic               phase;
    logic [AMP_W-1:0]   amp;

    logic [DIV_W-1:0]   half_c;
    logic               toggle_c;
    logic               boundary_c;
    logic               sound_c;
    logic               changed_c;
    logic               go_idle_c;
    logic [AMP_W-1:0]   env_tgt_c;
    logic [AMP_W:0]     up_c;
    logic [AMP_W:0]     dn_c;
    logic [AMP_W-1:0]   env_c;
    logic [AMP_W-1:0]   amp_nx_c;
    logic               phase_nx_c;
    logic [SMP_W-1:0]   mag_c;
    logic [SMP_W-1:0]   smp_c;

    // Period tracking, envelope step and the next amp/phase that feed the sample register.
    always_comb begin
        half_c     = div_l >> 1;
        toggle_c   = (cnt == half_c - DIV_W'(1));
        boundary_c = toggle_c && !phase;
        sound_c    = (note_div > DIV_W'(SILENCE_MAX));
        changed_c  = (note_div != div_l);
        go_idle_c  = (state == RELEASE) && !sound_c && tick && (amp == '0);
        env_tgt_c  = (state == PLAY) ? target_amp : '0;
        up_c       = (AMP_W+1)'(amp) + (AMP_W+1)'(AMP_STEP);
        dn_c       = (AMP_W+1)'(env_tgt_c) + (AMP_W+1)'(AMP_STEP);
        env_c      = amp;
        if (amp < env_tgt_c) begin
            env_c = (up_c > (AMP_W+1)'(env_tgt_c)) ? env_tgt_c : up_c[AMP_W-1:0];
        end else if (amp > env_tgt_c) begin
            env_c = ((AMP_W+1)'(amp) > dn_c) ? (amp - AMP_W'(AMP_STEP)) : env_tgt_c;
        end
        if (state == PLAY || state == RELEASE) begin
            amp_nx_c   = tick ? env_c : amp;
            phase_nx_c = go_idle_c ? 1'b0 : (toggle_c ? ~phase : phase);
        end else begin
            amp_nx_c   = '0;
            phase_nx_c = sound_c;
        end
        mag_c = {1'b0, amp_nx_c};
        smp_c = phase_nx_c ? mag_c : (SMP_W'(0) - mag_c);
    end

    // Channel state machine with registered sample and activity flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            div_l  <= DIV_W'(1);
            cnt    <= '0;
            phase  <= 1'b0;
            amp    <= '0;
            sample <= '0;
            active <= 1'b0;
        end else begin
            amp    <= amp_nx_c;
            phase  <= phase_nx_c;
            sample <= smp_c;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sound_c) begin
                        div_l  <= note_div;
                        state  <= PLAY;
                        active <= 1'b1;
                    end
                end
                PLAY: begin
                    cnt <= toggle_c ? '0 : cnt + DIV_W'(1);
                    if (!sound_c) begin
                        state <= RELEASE;
                    end else if (boundary_c && changed_c) begin
                        div_l <= note_div;
                    end
                end
                RELEASE: begin
                    cnt <= (toggle_c || go_idle_c) ? '0 : cnt + DIV_W'(1);
                    if (sound_c) begin
                        state <= PLAY;
                        if (boundary_c && changed_c) begin
                            div_l <= note_div;
                        end
                    end else if (go_idle_c) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tone_synth.sv
// Two-channel square-wave synth: shared envelope ramp timer, volume decode, channel pair.
module tone_synth
    import tone_pkg::*;
#(
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned RAMP_DIV = 1024,
    parameter logic [15:0] AMP_STEP = 16'h0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   note_div_left,
    input  logic [DIV_W-1:0]   note_div_right,
    input  logic [2:0]         volume,
    output logic [15:0]        audio_left,
    output logic [15:0]        audio_right,
    output logic [1:0]         active
);

    localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RAMP_W-1:0] ramp_cnt;
    logic              tick;
    logic [AMP_W-1:0]  target_c;
    logic              act_left;
    logic              act_right;

    assign tick     = (ramp_cnt == RAMP_W'(RAMP_DIV - 1));
    assign target_c = vol_to_amp(volume);

    // Free-running envelope step timer shared by both channels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ramp_cnt <= '0;
        end else if (tick) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + RAMP_W'(1);
        end
    end

    tone_channel #(
        .DIV_W    (DIV_W),
        .AMP_STEP (AMP_STEP)
    ) u_left (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .note_div   (note_div_left),
        .target_amp (target_c),
        .sample     (audio_left),
        .active     (act_left)
    );

    tone_channel #(
        .DIV_W    (DIV_W),
        .AMP_STEP (AMP_STEP)
    ) u_right (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .note_div   (note_div_right),
        .target_amp (target_c),
        .sample     (audio_right),
        .active     (act_right)
    );

    assign active = {act_left, act_right};

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with a short envelope step (RAMP_DIV = 4).
module tb_tone_synth;

    logic        clk;
    logic        rst;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic [2:0]  volume;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic [1:0]  active;

    int k     = 0;
    int n_cmp = 0;
    int n_bad = 0;

    tone_synth #(
        .DIV_W    (22),
        .RAMP_DIV (4),
        .AMP_STEP (16'h0100)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .volume         (volume),
        .audio_left     (audio_left),
        .audio_right    (audio_right),
        .active         (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after edge number 'target' (edges counted from the last reset release).
    task automatic go(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b0;
        note_div_left  = 22'd1000;
        note_div_right = 22'd1000;
        volume         = 3'd3;

        // Reset held three cycles with notes requested.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_audio_l", audio_left, 16'h0000);
            chk("rst_audio_r", audio_right, 16'h0000);
            chk("rst_active", 16'(active), 16'h0000);
        end
        rst = 1'b1;
        k   = 0;

        // Attack: IDLE->PLAY on first edge, envelope steps every 4th edge.
        go(1);    chk("start_active", 16'(active), 16'h0003);
                  chk("start_audio_l", audio_left, 16'h0000);
        go(3);    chk("pre_tick_l", audio_left, 16'h0000);
        go(4);    chk("tick1_l", audio_left, 16'h0100);
                  chk("tick1_r", audio_right, 16'h0100);
        go(127);  chk("attack_31_l", audio_left, 16'h1F00);
        go(128);  chk("attack_32_l", audio_left, 16'h2000);
        go(132);  chk("no_overshoot_l", audio_left, 16'h2000);

        // Half periods of 500 cycles.
        go(500);  chk("ph1_end_l", audio_left, 16'h2000);
        go(501);  chk("ph0_start_l", audio_left, 16'hE000);
                  chk("ph0_start_r", audio_right, 16'hE000);
        go(1000); chk("ph0_end_l", audio_left, 16'hE000);
        go(1001); chk("ph1_again_l", audio_left, 16'h2000);

        // Pitch change at cnt = 200 in phase 1; latch waits for the 0->1 toggle.
        go(1201); note_div_left = 22'd500;
        go(1500); chk("old_half_a", audio_left, 16'h2000);
        go(1501); chk("old_half_b", audio_left, 16'hE000);
        go(2000); chk("old_half_c", audio_left, 16'hE000);
        go(2001); chk("new_pitch_start", audio_left, 16'h2000);
                  chk("right_2001", audio_right, 16'h2000);
        go(2250); chk("new_half_end", audio_left, 16'h2000);
        go(2251); chk("new_half_toggle", audio_left, 16'hE000);
                  chk("right_indep", audio_right, 16'h2000);

        // Release from 0x2000 late in a phase-0 half; pitch 500 must continue.
        go(2451); note_div_left = 22'd1;
        go(2452); chk("rel_enter_l", audio_left, 16'hE000);
                  chk("rel_enter_act", 16'(active), 16'h0003);
        go(2456); chk("rel_step1", audio_left, 16'hE100);
        go(2500); chk("rel_step12_ph0", audio_left, 16'hEC00);
        go(2501); chk("rel_step12_ph1", audio_left, 16'h1400);
                  chk("right_2501", audio_right, 16'hE000);
        go(2579); chk("rel_last_step", audio_left, 16'h0100);
        go(2580); chk("rel_zero", audio_left, 16'h0000);
                  chk("rel_zero_act", 16'(active), 16'h0003);
        go(2583); chk("rel_wait_act", 16'(active), 16'h0003);
        go(2584); chk("idle_act", 16'(active), 16'h0001);
                  chk("idle_audio_l", audio_left, 16'h0000);
                  chk("right_2584", audio_right, 16'hE000);

        // Volume 7 clamps at 0x4000; new note 800 on the left.
        go(2600); note_div_left = 22'd800; volume = 3'd7;
        go(2601); chk("v7_start_act", 16'(active), 16'h0003);
                  chk("v7_start_l", audio_left, 16'h0000);
        go(2604); chk("v7_tick1_l", audio_left, 16'h0100);
                  chk("v7_tick1_r", audio_right, 16'hDF00);
        go(2728); chk("v7_right_full", audio_right, 16'hC000);
        go(2852); chk("v7_l_3f00", audio_left, 16'h3F00);
        go(2856); chk("v7_l_full", audio_left, 16'h4000);
        go(2860); chk("v7_l_clamp", audio_left, 16'h4000);
                  chk("v7_r_clamp", audio_right, 16'hC000);

        // Re-trigger during release: amp turns around without reaching 0.
        note_div_left = 22'd1;
        go(2861); chk("rt_rel_act", 16'(active), 16'h0003);
                  chk("rt_rel_l", audio_left, 16'h4000);
        go(2864); chk("rt_down1", audio_left, 16'h3F00);
        go(2892); chk("rt_down8", audio_left, 16'h3800);
        note_div_left = 22'd800;
        go(2893); chk("rt_play_act", 16'(active), 16'h0003);
                  chk("rt_hold", audio_left, 16'h3800);
        go(2896); chk("rt_up1", audio_left, 16'h3900);
        go(2924); chk("rt_full", audio_left, 16'h4000);

        // Volume 0: both channels fade to 0 but stay in PLAY.
        volume = 3'd0;
        go(2928); chk("v0_l_step1", audio_left, 16'h3F00);
                  chk("v0_r_step1", audio_right, 16'hC100);
        go(3000); chk("v0_l_mid", audio_left, 16'h2D00);
                  chk("v0_r_mid", audio_right, 16'hD300);
        go(3180); chk("v0_l_zero", audio_left, 16'h0000);
                  chk("v0_r_zero", audio_right, 16'h0000);
        go(3200); chk("v0_still_play", 16'(active), 16'h0003);

        // Volume 1 target 0x0800.
        volume = 3'd1;
        go(3204); chk("v1_l_step1", audio_left, 16'hFF00);
                  chk("v1_r_step1", audio_right, 16'h0100);
        go(3240); chk("v1_l_full", audio_left, 16'hF800);
                  chk("v1_r_full", audio_right, 16'h0800);

        // Reset mid-note silences immediately.
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_l", audio_left, 16'h0000);
        chk("midrst_r", audio_right, 16'h0000);
        chk("midrst_act", 16'(active), 16'h0000);

        // Minimum dividers: 2 and 3 both toggle every cycle.
        note_div_left  = 22'd2;
        note_div_right = 22'd3;
        volume         = 3'd5;
        rst            = 1'b1;
        k              = 0;
        go(1);  chk("min_act", 16'(active), 16'h0003);
                chk("min_audio_l", audio_left, 16'h0000);
        go(4);  chk("min_e4_l", audio_left, 16'hFF00);
                chk("min_e4_r", audio_right, 16'hFF00);
        go(5);  chk("min_e5_l", audio_left, 16'h0100);
                chk("min_e5_r", audio_right, 16'h0100);
        go(6);  chk("min_e6_l", audio_left, 16'hFF00);

        // Silence arriving on a 0->1 boundary: release wins, divider stays 2.
        go(12); chk("bnd_pre_l", audio_left, 16'hFD00);
        note_div_left = 22'd1;
        go(13); chk("bnd_e13_l", audio_left, 16'h0300);
        go(14); chk("bnd_e14_l", audio_left, 16'hFD00);
        go(16); chk("bnd_e16_l", audio_left, 16'hFE00);
                chk("bnd_e16_r", audio_right, 16'hFC00);
                chk("bnd_e16_act", 16'(active), 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
